ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding.
- Captures decoded instruction fields at the end of decode.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, then drives the ALU operand A, operand B and opcode inputs directly.
- Flags load-use hazards back to the hazard/stall controller.

Parameters:
- XLEN, 32, datapath width; must equal the ALU width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold the ID/EX register contents
- flush  in  1  replace the incoming instruction with a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW each  register indices
- id_alu_op  in  alu_op_e  ALU operation
- id_use_imm  in  1  B operand = immediate
- id_use_pc  in  1  A operand = PC
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- exmem_reg_write  in  1  EX/MEM stage writes a register
- exmem_rd  in  REG_AW  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB stage writes a register
- memwb_rd  in  REG_AW  MEM/WB destination
- memwb_result  in  XLEN  writeback value
- ex_valid  out  1  EX slot valid
- A  out  XLEN  ALU operand A
- B  out  XLEN  ALU operand B
- Opcode  out  alu_op_e  ALU operation
- ex_store_data  out  XLEN  forwarded rs2 value, for stores
- ex_pc  out  XLEN  registered PC
- ex_rd  out  REG_AW  registered destination
- ex_reg_write  out  1  registered write enable, gated by ex_valid
- ex_mem_read  out  1  registered load flag, gated by ex_valid
- load_use_hazard  out  1  the decode-stage instruction must stall

Behaviour:

Reset
- rst high at a clock edge clears every registered field to 0.
- Opcode resets to ALU_ADD.
- After reset: ex_valid=0, ex_reg_write=0, ex_mem_read=0, A=0, B=0, ex_store_data=0.
- A reset mid-stall or mid-flush has the same result; rst overrides everything.

Register update, each rising edge with rst low
- flush=1: load a bubble. valid=0, reg_write=0, mem_read=0, Opcode=ALU_ADD, remaining fields 0. flush has priority over stall.
- else stall=1: hold all fields unchanged.
- else: capture all id_* fields. Stored valid = id_valid. Stored reg_write and mem_read are ANDed with id_valid.

Latency
- One cycle from id_* to the registered fields.
- A, B, ex_store_data and load_use_hazard are combinational from the registered fields and the current forwarding inputs. There is no additional cycle.

Forwarding, applied independently to rs1 and rs2 (fields held in the register)
- If exmem_reg_write and exmem_rd != 0 and exmem_rd == rsN, use exmem_result.
- Else if memwb_reg_write and memwb_rd != 0 and memwb_rd == rsN, use memwb_result.
- Else use the registered rsN_data.
- EX/MEM has priority over MEM/WB.
- Register x0 is never forwarded.

Operand selection
- A = PC if use_pc, otherwise forwarded rs1.
- B = imm if use_imm, otherwise forwarded rs2.
- ex_store_data is always forwarded rs2, independent of use_imm.

Held values during stall
- While stall is held, forwarded values still track the current exmem/memwb inputs, so operands refresh as producers advance.

Load-use hazard
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (id_rs1_addr == ex_rd | id_rs2_addr == ex_rd).
- Purely combinational.
- Conservative: does not qualify on whether rs2 is actually used.

Invalid slots
- When ex_valid=0, A/B/Opcode still follow the register contents.
- Downstream stages must ignore them; ex_reg_write and ex_mem_read are already 0.

Test Plan:
- Reset then capture:
  - Stimulus: rst high 2 cycles, then id_valid=1, id_alu_op=ALU_SUB, rs1_data=10, rs2_data=3, no forwarding.
  - Response: the next cycle gives ex_valid=1, A=10, B=3, Opcode=ALU_SUB. During reset: all outputs 0, Opcode=ALU_ADD.
- Forward priority:
  - Stimulus: registered rs1=5; exmem (we=1, rd=5, result=0xAAAA); memwb (we=1, rd=5, result=0xBBBB).
  - Response: A=0xAAAA. Deassert exmem_reg_write -> A=0xBBBB.
- x0 guard:
  - Stimulus: rs2=0, exmem_rd=0, exmem_reg_write=1, result=0xFFFF, rs2_data=0.
  - Response: B=0 and ex_store_data=0.
- Immediate / PC select:
  - Stimulus: use_pc=1, use_imm=1, pc=0x100, imm=0xFFFFFFFC, rs2 forwarded 0x55.
  - Response: A=0x100, B=0xFFFFFFFC, ex_store_data=0x55.
- Stall / flush:
  - Stimulus: stall=1 for 3 cycles with id_* changing.
  - Response: registered fields are unchanged.
  - Stimulus: assert stall=1 and flush=1 together.
  - Response: the next cycle gives ex_valid=0, ex_reg_write=0.
- Load-use:
  - Stimulus: EX holds a load to rd=7; decode has id_valid=1, id_rs2_addr=7.
  - Response: load_use_hazard=1.
  - Stimulus: change ex_rd to 0, or set id_valid=0.
  - Response: load_use_hazard=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage RAW forwarding and load-use detection.
// Drives ALU operands A/B and Opcode directly from the held decode fields.
package ex_operand_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  alu_op_e           id_alu_op,
  input  logic              id_use_imm,
  input  logic              id_use_pc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output alu_op_e           Opcode,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              load_use_hazard
);

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  alu_op_e           op_q;
  logic              use_imm_q;
  logic              use_pc_q;
  logic              reg_write_q;
  logic              mem_read_q;

  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;

  // Reset and flush both load a bubble; stall holds; otherwise capture decode.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      op_q        <= ALU_ADD;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (!stall) begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1_addr;
      rs2_q       <= id_rs2_addr;
      rd_q        <= id_rd_addr;
      op_q        <= id_alu_op;
      use_imm_q   <= id_use_imm;
      use_pc_q    <= id_use_pc;
      reg_write_q <= id_reg_write & id_valid;
      mem_read_q  <= id_mem_read & id_valid;
    end
  end

  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  always_comb begin
    rs1_fwd = rs1_data_q;
    rs2_fwd = rs2_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
      rs1_fwd = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
      rs1_fwd = memwb_result;
    end
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
      rs2_fwd = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
      rs2_fwd = memwb_result;
    end
  end

  assign A             = use_pc_q  ? pc_q  : rs1_fwd;
  assign B             = use_imm_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign Opcode        = op_q;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_mem_read   = mem_read_q & valid_q;

  // Conservative: any rs match stalls, whether or not rs2 is consumed.
  assign load_use_hazard = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                           ((id_rs1_addr == rd_q) | (id_rs2_addr == rd_q));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: per-cycle compare against a pipeline-slot
// model, plus hand-computed literal checks for each scenario.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  alu_op_e     id_alu_op;
  logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
  logic [31:0] A, B, ex_store_data, ex_pc;
  logic [4:0]  ex_rd;
  alu_op_e     Opcode;

  int errors = 0;
  int checks = 0;

  ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op),
    .id_use_imm(id_use_imm), .id_use_pc(id_use_pc), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .ex_valid(ex_valid), .A(A), .B(B),
    .Opcode(Opcode), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .load_use_hazard(load_use_hazard)
  );

  always #10 clk = ~clk;

  // Instruction occupying the EX slot, as the model sees it.
  typedef struct {
    bit          valid;
    bit [31:0]   pc, d1, d2, imm;
    bit [4:0]    s1, s2, rd;
    alu_op_e     op;
    bit          ui, up, we, ld;
  } slot_t;

  slot_t m;
  bit    m_known = 1'b0;

  always @(posedge clk) begin
    if (rst || flush) begin
      m <= '{valid: 0, pc: 0, d1: 0, d2: 0, imm: 0, s1: 0, s2: 0, rd: 0,
             op: ALU_ADD, ui: 0, up: 0, we: 0, ld: 0};
      m_known <= 1'b1;
    end else if (!stall) begin
      m <= '{valid: id_valid, pc: id_pc, d1: id_rs1_data, d2: id_rs2_data,
             imm: id_imm, s1: id_rs1_addr, s2: id_rs2_addr, rd: id_rd_addr,
             op: id_alu_op, ui: id_use_imm, up: id_use_pc,
             we: id_reg_write && id_valid, ld: id_mem_read && id_valid};
    end
  end

  // Value an instruction reading register r actually sees, given the pipeline.
  function automatic bit [31:0] reg_value(bit [4:0] r, bit [31:0] rf);
    if (r == 0) return rf;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      bit hz;
      hz = m.valid && m.ld && m.rd != 0 && id_valid &&
           (id_rs1_addr == m.rd || id_rs2_addr == m.rd);
      chk("cyc_valid", 64'(ex_valid), 64'(m.valid));
      chk("cyc_A", 64'(A), 64'(m.up ? m.pc : reg_value(m.s1, m.d1)));
      chk("cyc_B", 64'(B), 64'(m.ui ? m.imm : reg_value(m.s2, m.d2)));
      chk("cyc_store", 64'(ex_store_data), 64'(reg_value(m.s2, m.d2)));
      chk("cyc_op", 64'(Opcode), 64'(m.op));
      chk("cyc_pc", 64'(ex_pc), 64'(m.pc));
      chk("cyc_rd", 64'(ex_rd), 64'(m.rd));
      chk("cyc_we", 64'(ex_reg_write), 64'(m.we));
      chk("cyc_ld", 64'(ex_mem_read), 64'(m.ld));
      chk("cyc_hazard", 64'(load_use_hazard), 64'(hz));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_op = ALU_ADD;
    id_use_imm = 0; id_use_pc = 0; id_reg_write = 0; id_mem_read = 0;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    clear_id(); clear_fwd();
    id_valid = 1; id_reg_write = 1; id_rs1_data = 32'h1234;
    tick(); tick();
    #1;
    chk("rst_valid", 64'(ex_valid), 0);
    chk("rst_A", 64'(A), 0);
    chk("rst_B", 64'(B), 0);
    chk("rst_store", 64'(ex_store_data), 0);
    chk("rst_op", 64'(Opcode), 64'(ALU_ADD));
    chk("rst_we", 64'(ex_reg_write), 0);
    chk("rst_ld", 64'(ex_mem_read), 0);

    // Reset then capture
    rst = 0; clear_id();
    id_valid = 1; id_alu_op = ALU_SUB; id_rs1_addr = 1; id_rs2_addr = 2;
    id_rs1_data = 10; id_rs2_data = 3; id_rd_addr = 3; id_reg_write = 1;
    tick(); #1;
    chk("cap_valid", 64'(ex_valid), 1);
    chk("cap_A", 64'(A), 10);
    chk("cap_B", 64'(B), 3);
    chk("cap_op", 64'(Opcode), 64'(ALU_SUB));
    chk("cap_we", 64'(ex_reg_write), 1);

    // Forward priority
    clear_id();
    id_valid = 1; id_rs1_addr = 5; id_rs1_data = 1; id_rs2_addr = 6; id_rs2_data = 2;
    tick();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBBBB;
    #1 chk("fwd_exmem_A", 64'(A), 32'hAAAA);
    chk("fwd_B_untouched", 64'(B), 2);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb_A", 64'(A), 32'hBBBB);
    memwb_reg_write = 0;
    #1 chk("fwd_none_A", 64'(A), 1);
    clear_fwd();

    // x0 guard
    clear_id();
    id_valid = 1; id_rs1_addr = 0; id_rs2_addr = 0;
    tick();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h1234;
    #1 chk("x0_B", 64'(B), 0);
    chk("x0_store", 64'(ex_store_data), 0);
    chk("x0_A", 64'(A), 0);
    clear_fwd();

    // Immediate / PC select
    clear_id();
    id_valid = 1; id_use_pc = 1; id_use_imm = 1; id_pc = 32'h100; id_imm = 32'hFFFF_FFFC;
    id_rs1_addr = 9; id_rs1_data = 7; id_rs2_addr = 9; id_rs2_data = 32'h11;
    tick();
    exmem_reg_write = 1; exmem_rd = 9; exmem_result = 32'h55;
    #1 chk("sel_A_pc", 64'(A), 32'h100);
    chk("sel_B_imm", 64'(B), 32'hFFFF_FFFC);
    chk("sel_store_fwd", 64'(ex_store_data), 32'h55);
    clear_fwd();

    // Stall holds registered fields while forwarding stays live
    clear_id();
    id_valid = 1; id_rs1_addr = 3; id_rs1_data = 32'h30; id_rs2_addr = 4;
    id_rs2_data = 32'h40; id_pc = 32'h200; id_rd_addr = 8; id_alu_op = ALU_OR;
    id_reg_write = 1;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs1_data = 32'h1000 + 32'(i); id_rs2_data = 32'h2000 + 32'(i);
      id_pc = 32'h300 + 32'(i); id_rd_addr = 5'(10 + i); id_alu_op = ALU_XOR;
      id_valid = (i != 1);
      tick(); #1;
      chk("stall_A", 64'(A), 32'h30);
      chk("stall_B", 64'(B), 32'h40);
      chk("stall_pc", 64'(ex_pc), 32'h200);
      chk("stall_rd", 64'(ex_rd), 8);
      chk("stall_op", 64'(Opcode), 64'(ALU_OR));
    end
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h99;
    #1 chk("stall_fwd_A", 64'(A), 32'h99);
    clear_fwd();

    // Flush wins over stall
    flush = 1;
    tick(); #1;
    chk("flush_valid", 64'(ex_valid), 0);
    chk("flush_we", 64'(ex_reg_write), 0);
    chk("flush_op", 64'(Opcode), 64'(ALU_ADD));
    chk("flush_pc", 64'(ex_pc), 0);
    flush = 0; stall = 0;

    // Load-use
    clear_id();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 7;
    tick();
    clear_id();
    id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 7;
    #1 chk("lu_rs2", 64'(load_use_hazard), 1);
    id_valid = 0;
    #1 chk("lu_id_invalid", 64'(load_use_hazard), 0);
    id_valid = 1; id_rs1_addr = 7; id_rs2_addr = 0;
    #1 chk("lu_rs1", 64'(load_use_hazard), 1);
    id_mem_read = 1; id_rd_addr = 0;
    tick();
    id_mem_read = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    #1 chk("lu_rd0", 64'(load_use_hazard), 0);
    id_valid = 0; id_mem_read = 1; id_rd_addr = 7;
    tick();
    id_valid = 1; id_mem_read = 0; id_rs2_addr = 7;
    #1 chk("lu_gated_ld", 64'(ex_mem_read), 0);
    chk("lu_gated_hz", 64'(load_use_hazard), 0);

    // Reset during stall
    clear_id();
    id_valid = 1; id_reg_write = 1; id_rd_addr = 4; id_alu_op = ALU_SLT;
    tick();
    stall = 1; rst = 1;
    tick(); #1;
    chk("rst_stall_valid", 64'(ex_valid), 0);
    chk("rst_stall_rd", 64'(ex_rd), 0);
    chk("rst_stall_op", 64'(Opcode), 64'(ALU_ADD));
    rst = 0; stall = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
